// File: rtl/seg7_scan_driver_if.sv
// Producer-side bus of the 7-segment scan driver: value/dp load port, blanking control, status.
// With SEG7_BLINK_EN defined the bus also carries the per-digit blink mask.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic                    pending;
  logic                    frame_tick;

`ifdef SEG7_BLINK_EN
  modport master (output load, value, dp_in, blank_lz, blink_mask, input pending, frame_tick);
  modport slave  (input load, value, dp_in, blank_lz, blink_mask, output pending, frame_tick);
`else
  modport master (output load, value, dp_in, blank_lz, input pending, frame_tick);
  modport slave  (input load, value, dp_in, blank_lz, output pending, frame_tick);
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment driver with frame-synchronous double buffering, leading-zero
// blanking and anti-ghosting dead time. Optional digit blinking is enabled by SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 262144,
  parameter int DEAD_CYCLES = 1024,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  seg7_scan_driver_if.slave     bus,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            cathode,
  output logic                  dp
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  // slot counter runs down, so the lit part of the slot is the low end of the count
  localparam logic [SLOT_W-1:0] LIT_FROM  = SLOT_W'(REFRESH_DIV - 1 - DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic              INV       = (ACTIVE_LOW != 0);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < DEAD_CYCLES + 2) begin : g_bad_refresh
    $error("seg7_scan_driver: REFRESH_DIV must be >= DEAD_CYCLES+2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("seg7_scan_driver: BLINK_DIV must be >= 1");
  end

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] shown_val;
  logic [NUM_DIGITS-1:0]   shown_dp;
  logic                    pending_r;
  logic                    frame_tick_r;

  logic                    slot_end;
  logic                    frame_wrap;

  assign slot_end   = (slot_cnt == '0);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      slot_cnt     <= SLOT_LAST;
      idx          <= '0;
      pend_val     <= '0;
      pend_dp      <= '0;
      shown_val    <= '0;
      shown_dp     <= '0;
      pending_r    <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= frame_wrap;
      if (slot_end) begin
        slot_cnt <= SLOT_LAST;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt - 1'b1;
      end
      // a load on the wrap cycle still lets the older buffer commit first
      if (frame_wrap && pending_r) begin
        shown_val <= pend_val;
        shown_dp  <= pend_dp;
      end
      if (bus.load) begin
        pend_val  <= bus.value;
        pend_dp   <= bus.dp_in;
        pending_r <= 1'b1;
      end else if (frame_wrap) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign bus.pending    = pending_r;
  assign bus.frame_tick = frame_tick_r;

`ifdef SEG7_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic               blink_hide;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      blink_cnt <= BLINK_LAST;
      blink_on  <= 1'b1;
    end else if (blink_cnt == '0) begin
      blink_cnt <= BLINK_LAST;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  assign blink_hide = !blink_on && bus.blink_mask[idx];
`else
  logic blink_hide;
  assign blink_hide = 1'b0;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  logic [3:0]            cur_nib;
  logic [IDX_W-1:0]      top_nz;
  logic                  blank_digit;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] anode_on;
  logic [6:0]            seg_on;
  logic                  dp_on;

  assign cur_nib = shown_val[{idx, 2'b00} +: 4];

  // digit 0 is never above top_nz, so an all-zero value still shows "0"
  always_comb begin
    top_nz = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (shown_val[4*k +: 4] != 4'h0) top_nz = IDX_W'(k);
    end
  end

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  assign blank_digit = bus.blank_lz && (idx > top_nz);
  assign anode_on    = (slot_cnt <= LIT_FROM) ? onehot : '0;
  assign seg_on      = (blank_digit || blink_hide) ? 7'b0000000 : seg_decode(cur_nib);
  assign dp_on       = shown_dp[idx] && !blink_hide;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      anode   <= {NUM_DIGITS{INV}};
      cathode <= {7{INV}};
      dp      <= INV;
    end else begin
      anode   <= anode_on ^ {NUM_DIGITS{INV}};
      cathode <= seg_on ^ {7{INV}};
      dp      <= dp_on ^ INV;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 dead cycles, active-low pins).
// Blink checks are included when SEG7_BLINK_EN is defined.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;

  logic          clock_100Mhz = 1'b0;
  logic          reset = 1'b1;
  logic [ND-1:0] anode;
  logic [6:0]    cathode;
  logic          dp;
  int            checks = 0;
  int            failures = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .ACTIVE_LOW(1), .BLINK_DIV(64)
  ) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset(reset),
    .bus(bus),
    .anode(anode),
    .cathode(cathode),
    .dp(dp)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.frame_tick !== 1'b1 && n < 40);
    chk("tick_seen", bus.frame_tick, 1'b1);
  endtask

  // called right after a frame_tick (or reset release); samples slot 2 of each digit
  task automatic scan_check(input string tag, input logic [27:0] ec, input logic [3:0] edp);
    logic [3:0] ea;
    for (int d = 0; d < ND; d++) begin
      repeat (d == 0 ? 3 : 8) step();
      ea = ~(4'b0001 << d);
      chk({tag, "_anode"}, anode, ea);
      chk({tag, "_cath"}, cathode, ec[d*7 +: 7]);
      chk({tag, "_dp"}, dp, edp[d]);
    end
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    bus.load  = 1'b1;
    bus.value = v;
    bus.dp_in = d;
    step();
    bus.load  = 1'b0;
  endtask

  initial begin
    logic [3:0] ea;
    int slot, dig;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.dp_in    = '0;
    bus.blank_lz = 1'b0;
`ifdef SEG7_BLINK_EN
    bus.blink_mask = '0;
`endif
    repeat (3) step();
    chk("rst_anode", anode, 4'hF);
    chk("rst_cath", cathode, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_pending", bus.pending, 1'b0);
    chk("rst_tick", bus.frame_tick, 1'b0);
    @(negedge clock_100Mhz) reset = 1'b0;

    for (int e = 1; e <= 33; e++) begin
      step();
      slot = (e - 1) % RD;
      dig  = ((e - 1) / RD) % ND;
      ea   = (slot < DC) ? 4'hF : ~(4'b0001 << dig);
      chk("scan_anode", anode, ea);
      chk("scan_tick", bus.frame_tick, (e == 32));
    end
    chk("idle_pending", bus.pending, 1'b0);

    // double-buffered load of 12AF, dp on digit 2
    wait_tick();
    step();
    load_val(16'h12AF, 4'b0100);
    chk("load_pending", bus.pending, 1'b1);
    repeat (20) step();
    chk("hold_pending", bus.pending, 1'b1);
    chk("hold_old_cath", cathode, 7'b0000001);
    wait_tick();
    chk("commit_pending", bus.pending, 1'b0);
    scan_check("h12AF", {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1011);

    // leading-zero blanking, then live switch-off
    bus.blank_lz = 1'b1;
    load_val(16'h0050, 4'b0000);
    wait_tick();
    scan_check("lz_on", {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b1111);
    bus.blank_lz = 1'b0;
    wait_tick();
    scan_check("lz_off", {7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001}, 4'b1111);

    // later load overwrites within a frame
    bus.load = 1'b1; bus.value = 16'h1111; bus.dp_in = 4'b0000;
    step();
    bus.value = 16'h2222;
    step();
    bus.load = 1'b0;
    wait_tick();
    scan_check("last_load", {4{7'b0010010}}, 4'b1111);

    // load exactly on the wrap cycle while 3333 is pending
    load_val(16'h3333, 4'b0000);
    repeat (3) step();
    load_val(16'h4444, 4'b0000);
    chk("wrap_tick", bus.frame_tick, 1'b1);
    chk("wrap_pending", bus.pending, 1'b1);
    scan_check("wrap_commit", {4{7'b0000110}}, 4'b1111);
    wait_tick();
    chk("wrap_next_pending", bus.pending, 1'b0);
    scan_check("wrap_next", {4{7'b1001100}}, 4'b1111);

    // reset mid-slot with data pending
    load_val(16'h5555, 4'b1111);
    chk("pre_rst_pending", bus.pending, 1'b1);
    step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_anode", anode, 4'hF);
    chk("mid_rst_cath", cathode, 7'h7F);
    chk("mid_rst_dp", dp, 1'b1);
    chk("mid_rst_pending", bus.pending, 1'b0);
    repeat (2) step();
    @(negedge clock_100Mhz) reset = 1'b0;
    scan_check("after_rst", {4{7'b0000001}}, 4'b1111);
    wait_tick();
    scan_check("dropped", {4{7'b0000001}}, 4'b1111);

`ifdef SEG7_BLINK_EN
    bus.blink_mask = 4'b0001;
    reset = 1'b1;
    repeat (2) step();
    @(negedge clock_100Mhz) reset = 1'b0;
    for (int e = 1; e <= 256; e++) begin
      step();
      slot = (e - 1) % RD;
      dig  = ((e - 1) / RD) % ND;
      if (slot >= DC && dig == 0)
        chk("blink_d0", cathode, (((e - 1) / 64) % 2 == 0) ? 7'b0000001 : 7'b1111111);
      if (slot >= DC && dig == 1)
        chk("blink_d1", cathode, 7'b0000001);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
